// File: rtl/rtc_core.sv
// rtl/rtc_core.sv - time-of-day counter with fractional period, timed adjustment and capture
// Holds ns.fraction and seconds, advanced by a programmable per-clock period.
module rtc_core #(
   parameter int NS_W      = 30,
   parameter int FRAC_W    = 8,
   parameter int PINT_W    = 8,
   parameter int PFRAC_W   = 32,
   parameter int SEC_W     = 48,
   parameter int NS_MODULO = 1000000000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      period_ld,
   input  logic [PINT_W+PFRAC_W-1:0] period_in,
   input  logic                      time_ld,
   input  logic [NS_W+FRAC_W-1:0]    time_ns_in,
   input  logic [SEC_W-1:0]          time_sec_in,
   output logic                      time_ld_err,
   input  logic                      adj_ld,
   input  logic [31:0]               adj_cnt,
   input  logic [PINT_W+PFRAC_W-1:0] period_adj,
   output logic                      adj_busy,
   output logic                      adj_done,
   input  logic                      cap_req,
   output logic [NS_W+FRAC_W-1:0]    cap_ns,
   output logic [SEC_W-1:0]          cap_sec,
   output logic                      cap_vld,
   output logic [NS_W+FRAC_W-1:0]    time_ns,
   output logic [SEC_W-1:0]          time_sec,
   output logic                      pps
);

   localparam int PW = PINT_W + PFRAC_W;
   localparam int AW = NS_W + PFRAC_W;
   localparam int TW = NS_W + FRAC_W;
   localparam logic [AW:0] MOD_FIX = (AW+1)'(NS_MODULO) << PFRAC_W;

   typedef enum logic {IDLE, ADJ} adj_state_t;

   adj_state_t        state, state_nxt;
   logic [31:0]       adj_left, adj_left_nxt;
   logic [PW-1:0]     adj_val;
   logic              adj_val_ld;
   logic              done_nxt;

   logic [PW-1:0]     period;
   logic [AW-1:0]     acc, acc_nxt;
   logic signed [PW+1:0] inc_s;
   logic [PW:0]       inc;
   logic [AW:0]       sum;
   logic              wrap;
   logic              ld_ok;

   always_comb begin
      state_nxt    = state;
      adj_left_nxt = adj_left;
      adj_val_ld   = 1'b0;
      done_nxt     = 1'b0;
      if (adj_ld) begin
         // A new request always replaces any running one; a zero count completes at once.
         if (adj_cnt != 32'd0) begin
            state_nxt    = ADJ;
            adj_left_nxt = adj_cnt;
            adj_val_ld   = 1'b1;
         end else begin
            state_nxt    = IDLE;
            adj_left_nxt = 32'd0;
            done_nxt     = 1'b1;
         end
      end else if (state == ADJ) begin
         if (adj_left == 32'd1) begin
            state_nxt    = IDLE;
            adj_left_nxt = 32'd0;
            done_nxt     = 1'b1;
         end else begin
            adj_left_nxt = adj_left - 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         adj_left <= 32'd0;
         adj_val  <= '0;
         adj_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         adj_left <= adj_left_nxt;
         adj_done <= done_nxt;
         if (adj_val_ld)
            adj_val <= period_adj;
      end
   end

   assign adj_busy = (state == ADJ);

   always_comb begin
      inc_s = $signed({2'b00, period});
      if (state == ADJ)
         inc_s = inc_s + $signed({{2{adj_val[PW-1]}}, adj_val});
      // Clamp so a large negative adjustment freezes time instead of reversing it.
      inc     = inc_s[PW+1] ? '0 : inc_s[PW:0];
      sum     = {1'b0, acc} + (AW+1)'(inc);
      wrap    = (sum >= MOD_FIX);
      acc_nxt = AW'(wrap ? sum - MOD_FIX : sum);
      ld_ok   = time_ld && (time_ns_in[TW-1:FRAC_W] < NS_W'(NS_MODULO));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period      <= '0;
         acc         <= '0;
         time_sec    <= '0;
         pps         <= 1'b0;
         time_ld_err <= 1'b0;
         cap_ns      <= '0;
         cap_sec     <= '0;
         cap_vld     <= 1'b0;
      end else begin
         if (period_ld)
            period <= period_in;
         if (ld_ok) begin
            acc      <= {time_ns_in, {(PFRAC_W-FRAC_W){1'b0}}};
            time_sec <= time_sec_in;
            pps      <= 1'b0;
         end else begin
            acc <= acc_nxt;
            pps <= wrap;
            if (wrap)
               time_sec <= time_sec + 1'b1;
         end
         time_ld_err <= time_ld && !ld_ok;
         cap_vld     <= cap_req;
         if (cap_req) begin
            cap_ns  <= time_ns;
            cap_sec <= time_sec;
         end
      end
   end

   assign time_ns = acc[AW-1 -: TW];

endmodule

// File: tb/tb_rtc_core.sv
// tb/tb_rtc_core.sv - directed vector bench for rtc_core
// Uses NS_MODULO=1000000 so second rollovers are reachable quickly.
module tb_rtc_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        period_ld;
   logic [39:0] period_in;
   logic        time_ld;
   logic [37:0] time_ns_in;
   logic [47:0] time_sec_in;
   logic        time_ld_err;
   logic        adj_ld;
   logic [31:0] adj_cnt;
   logic [39:0] period_adj;
   logic        adj_busy;
   logic        adj_done;
   logic        cap_req;
   logic [37:0] cap_ns;
   logic [47:0] cap_sec;
   logic        cap_vld;
   logic [37:0] time_ns;
   logic [47:0] time_sec;
   logic        pps;

   int checks = 0;
   int errors = 0;

   localparam logic [39:0] P8    = 40'h08_00000000;
   localparam logic [39:0] PNEG  = 40'hF0_00000000;
   localparam logic [39:0] PFRAC = 40'h08_10200000;

   always #5 clk = ~clk;

   rtc_core #(.NS_MODULO(1000000)) dut (
      .clk(clk), .rst(rst),
      .period_ld(period_ld), .period_in(period_in),
      .time_ld(time_ld), .time_ns_in(time_ns_in), .time_sec_in(time_sec_in),
      .time_ld_err(time_ld_err),
      .adj_ld(adj_ld), .adj_cnt(adj_cnt), .period_adj(period_adj),
      .adj_busy(adj_busy), .adj_done(adj_done),
      .cap_req(cap_req), .cap_ns(cap_ns), .cap_sec(cap_sec), .cap_vld(cap_vld),
      .time_ns(time_ns), .time_sec(time_sec), .pps(pps)
   );

   typedef struct {
      logic        pld;
      logic [39:0] pin;
      logic        tld;
      logic [37:0] nsin;
      logic [47:0] secin;
      logic [37:0] ens;
      logic [47:0] esec;
      logic        epps;
      logic        eerr;
   } row_t;

   row_t rows[25];

   function automatic logic [37:0] ns(input int n);
      return 38'(n) << 8;
   endfunction

   function automatic row_t mk(input logic a_pld, input logic [39:0] a_pin,
                               input logic a_tld, input logic [37:0] a_ns,
                               input logic [47:0] a_sec, input logic [37:0] e_ns,
                               input logic [47:0] e_sec, input logic e_pps,
                               input logic e_err);
      row_t r;
      r.pld = a_pld; r.pin = a_pin; r.tld = a_tld; r.nsin = a_ns; r.secin = a_sec;
      r.ens = e_ns; r.esec = e_sec; r.epps = e_pps; r.eerr = e_err;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      period_ld = 0; period_in = '0; time_ld = 0; time_ns_in = '0; time_sec_in = '0;
      adj_ld = 0; adj_cnt = '0; period_adj = '0; cap_req = 0;
   endtask

   task automatic load_time_zero();
      time_ld = 1; time_ns_in = '0; time_sec_in = '0;
      step();
      time_ld = 0;
   endtask

   initial begin
      int nb, nd, bad, n;
      logic [37:0] e;

      rows[0] = mk(0, '0, 0, '0, '0, ns(0), 0, 0, 0);
      rows[1] = mk(1, P8, 0, '0, '0, ns(0), 0, 0, 0);
      rows[2] = mk(0, '0, 0, '0, '0, ns(8), 0, 0, 0);
      rows[3] = mk(0, '0, 1, ns(999900), 48'd10, ns(999900), 10, 0, 0);
      for (int k = 1; k <= 13; k++) begin
         int v;
         int s;
         v = 999900 + 8 * k;
         s = 10;
         if (v >= 1000000) begin
            v = v - 1000000;
            s = 11;
         end
         rows[3+k] = mk(0, '0, 0, '0, '0, ns(v), 48'(s), k == 13, 0);
      end
      rows[17] = mk(0, '0, 0, '0, '0, ns(12), 11, 0, 0);
      rows[18] = mk(0, '0, 1, ns(1000000), 48'd5, ns(20), 11, 0, 1);
      rows[19] = mk(0, '0, 0, '0, '0, ns(28), 11, 0, 0);
      rows[20] = mk(0, '0, 1, ns(500) | 38'hAB, 48'd7, ns(500) | 38'hAB, 7, 0, 0);
      rows[21] = mk(0, '0, 0, '0, '0, ns(508) | 38'hAB, 7, 0, 0);
      rows[22] = mk(0, '0, 1, ns(999996), 48'hFFFF_FFFF_FFFF, ns(999996), 48'hFFFF_FFFF_FFFF, 0, 0);
      rows[23] = mk(0, '0, 0, '0, '0, ns(4), 0, 1, 0);
      rows[24] = mk(0, '0, 0, '0, '0, ns(12), 0, 0, 0);

      idle_inputs();
      rst = 1;
      step();
      step();
      chk("reset_ns", 64'(time_ns), 0);
      chk("reset_sec", 64'(time_sec), 0);
      chk("reset_flags", {58'd0, adj_busy, adj_done, cap_vld, pps, time_ld_err, 1'b0}, 0);
      rst = 0;

      for (int i = 0; i < 25; i++) begin
         period_ld = rows[i].pld; period_in = rows[i].pin;
         time_ld = rows[i].tld; time_ns_in = rows[i].nsin; time_sec_in = rows[i].secin;
         step();
         idle_inputs();
         checks++;
         if (time_ns !== rows[i].ens || time_sec !== rows[i].esec ||
             pps !== rows[i].epps || time_ld_err !== rows[i].eerr) begin
            errors++;
            $display("FAIL row%0d: got ns=%0h sec=%0h pps=%b err=%b expected ns=%0h sec=%0h pps=%b err=%b",
                     i, time_ns, time_sec, pps, time_ld_err,
                     rows[i].ens, rows[i].esec, rows[i].epps, rows[i].eerr);
         end
      end

      // Positive adjustment: 100 cycles at 16 ns each.
      load_time_zero();
      adj_ld = 1; adj_cnt = 100; period_adj = P8;
      step();
      adj_ld = 0;
      chk("adjp_start_ns", 64'(time_ns), 64'(ns(8)));
      n = 0; bad = 0; nd = 0;
      while (adj_busy === 1'b1 && n < 300) begin
         step();
         n++;
         if (time_ns !== ns(8 + 16 * n)) bad++;
         if (adj_done === 1'b1) nd++;
      end
      chk("adjp_busy_cycles", 64'(n), 100);
      chk("adjp_step_errs", 64'(bad), 0);
      chk("adjp_done_pulses", 64'(nd), 1);
      chk("adjp_end_ns", 64'(time_ns), 64'(ns(1608)));
      step();
      chk("adjp_after_ns", 64'(time_ns), 64'(ns(1616)));
      chk("adjp_done_clear", 64'(adj_done), 0);

      // Negative adjustment larger than the period: time freezes.
      load_time_zero();
      adj_ld = 1; adj_cnt = 100; period_adj = PNEG;
      step();
      adj_ld = 0;
      n = 0; bad = 0;
      while (adj_busy === 1'b1 && n < 300) begin
         step();
         n++;
         if (time_ns !== ns(8)) bad++;
      end
      chk("adjn_busy_cycles", 64'(n), 100);
      chk("adjn_frozen_errs", 64'(bad), 0);
      step();
      chk("adjn_resume1", 64'(time_ns), 64'(ns(16)));
      step();
      chk("adjn_resume2", 64'(time_ns), 64'(ns(24)));

      // Restart while running: 2 cycles of the first request, then 5 of the second.
      adj_ld = 1; adj_cnt = 10; period_adj = '0;
      step();
      adj_ld = 0;
      nb = 0; nd = 0;
      for (int i = 0; i < 20; i++) begin
         if (adj_busy === 1'b1) nb++;
         if (adj_done === 1'b1) nd++;
         if (i == 1) begin
            adj_ld = 1; adj_cnt = 5;
         end
         step();
         adj_ld = 0;
      end
      chk("restart_busy_cycles", 64'(nb), 7);
      chk("restart_done_pulses", 64'(nd), 1);

      // Zero-count request completes immediately.
      adj_ld = 1; adj_cnt = 0; period_adj = P8;
      step();
      adj_ld = 0;
      chk("zero_cnt_busy", 64'(adj_busy), 0);
      chk("zero_cnt_done", 64'(adj_done), 1);
      step();
      chk("zero_cnt_done_clear", 64'(adj_done), 0);

      // Fractional period with simultaneous period and time load, then captures.
      period_ld = 1; period_in = PFRAC;
      time_ld = 1; time_ns_in = '0; time_sec_in = '0;
      step();
      idle_inputs();
      chk("frac_loaded", 64'(time_ns), 0);
      for (int i = 0; i < 1024; i++) step();
      e = ns(8256) | 38'h80;
      chk("frac_1024", 64'(time_ns), 64'(e));
      cap_req = 1;
      step();
      chk("cap1_vld", 64'(cap_vld), 1);
      chk("cap1_ns", 64'(cap_ns), 64'(e));
      chk("cap1_sec", 64'(cap_sec), 0);
      chk("frac_1025", 64'(time_ns), 64'(ns(8264) | 38'h90));
      step();
      cap_req = 0;
      chk("cap2_vld", 64'(cap_vld), 1);
      chk("cap2_ns", 64'(cap_ns), 64'(ns(8264) | 38'h90));
      step();
      chk("cap_vld_clear", 64'(cap_vld), 0);

      // Reset in the middle of an adjustment, overriding simultaneous loads.
      adj_ld = 1; adj_cnt = 50; period_adj = P8;
      step();
      adj_ld = 0;
      step();
      step();
      chk("mid_adj_busy", 64'(adj_busy), 1);
      rst = 1; period_ld = 1; period_in = P8; time_ld = 1; time_ns_in = ns(77); cap_req = 1;
      step();
      idle_inputs();
      chk("rst_ns", 64'(time_ns), 0);
      chk("rst_sec", 64'(time_sec), 0);
      chk("rst_caps", 64'(cap_ns) | 64'(cap_sec), 0);
      chk("rst_flags", {58'd0, adj_busy, adj_done, cap_vld, pps, time_ld_err, 1'b0}, 0);
      rst = 0;
      nd = 0; bad = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (adj_done !== 1'b0) nd++;
         if (time_ns !== '0 || adj_busy !== 1'b0) bad++;
      end
      chk("post_rst_done", 64'(nd), 0);
      chk("post_rst_still", 64'(bad), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtc_core.md
RTC_CORE -- requirements
Module: rtc_core

Interface
REQ-001 SHALL have parameter NS_W, default 30: integer-ns width of the time register.
REQ-002 SHALL have parameter FRAC_W, default 8: ns-fraction bits presented on time outputs.
REQ-003 SHALL have parameter PINT_W, default 8: integer-ns width of the period and the adjustment.
REQ-004 SHALL have parameter PFRAC_W, default 32: ns-fraction width of the period, adjustment and internal accumulator.
REQ-005 SHALL have parameter SEC_W, default 48: seconds width.
REQ-006 SHALL have parameter NS_MODULO, default 1000000000: ns per second, the wrap point of the ns field.
REQ-007 SHALL have ports, clock and reset first:
 clk  in  1  sole clock, rising edge
 rst  in  1  synchronous, active-high reset
 period_ld  in  1  load period_in
 period_in  in  PINT_W+PFRAC_W  unsigned nominal ns per clk
 time_ld  in  1  load ToD
 time_ns_in  in  NS_W+FRAC_W  ns.fraction to load
 time_sec_in  in  SEC_W  seconds to load
 time_ld_err  out  1  one-cycle pulse: time load rejected
 adj_ld  in  1  start timed adjustment
 adj_cnt  in  32  number of adjusted cycles
 period_adj  in  PINT_W+PFRAC_W  signed two's-complement offset added to the period
 adj_busy  out  1  adjustment in progress
 adj_done  out  1  one-cycle completion pulse
 cap_req  in  1  timestamp capture request
 cap_ns  out  NS_W+FRAC_W  captured ns.fraction
 cap_sec  out  SEC_W  captured seconds
 cap_vld  out  1  one-cycle pulse: capture valid
 time_ns  out  NS_W+FRAC_W  live ns.fraction
 time_sec  out  SEC_W  live seconds
 pps  out  1  one-cycle pulse on second rollover

Function
REQ-008 Internal ns accumulator SHALL be NS_W+PFRAC_W bits; time_ns SHALL equal its top NS_W+FRAC_W bits (truncation, no rounding).
REQ-009 Every non-load cycle, increment SHALL be period when adj_busy=0, else period + sign-extended period_adj.
REQ-010 A negative increment SHALL saturate to 0, so time holds and never runs backwards.
REQ-011 When accumulator + increment >= NS_MODULO<<PFRAC_W, the ns field SHALL take the sum minus NS_MODULO<<PFRAC_W, time_sec SHALL increment modulo 2^SEC_W, and pps SHALL pulse in that same output cycle.
REQ-012 period_ld SHALL register period_in at the edge; the new period governs the next cycle's increment onward.
REQ-013 time_ld with integer(time_ns_in) < NS_MODULO SHALL load ns.fraction (lower fraction bits zeroed) and seconds at the edge, visible the next cycle, replacing that cycle's increment; pps SHALL NOT pulse.
REQ-014 time_ld with integer(time_ns_in) >= NS_MODULO SHALL be ignored and pulse time_ld_err for one cycle; counting continues.
REQ-015 Adjustment FSM SHALL have states IDLE and ADJ. IDLE->ADJ on adj_ld with adj_cnt>0, latching period_adj and adj_cnt. In ADJ the counter decrements each cycle; at reaching 0 -> IDLE with adj_done pulsing one cycle. adj_busy=1 exactly while in ADJ, i.e. adj_cnt cycles.
REQ-016 adj_ld with adj_cnt=0 SHALL leave the FSM in IDLE and pulse adj_done the next cycle.
REQ-017 adj_ld while in ADJ SHALL restart with the new adj_cnt/period_adj, with no adj_done for the aborted request.
REQ-018 time_ld and period_ld SHALL NOT alter the adjustment FSM.
REQ-019 cap_req SHALL register the time_ns/time_sec values present that cycle into cap_ns/cap_sec, with cap_vld pulsing the next cycle; back-to-back requests capture every cycle.
REQ-020 Simultaneous period_ld, time_ld, adj_ld and cap_req SHALL all take effect independently in the same cycle.

Reset
REQ-021 rst=1 at a rising edge SHALL clear the accumulator, seconds, period, latched adjustment and captures to 0, force IDLE, and drive every output to 0, overriding all loads, including mid-adjustment.
REQ-022 After reset, time SHALL not advance until a nonzero period is loaded.

Verification (NS_MODULO=1000000)
REQ-023 Load period 8.0 ns, then time 999900 ns / sec 10 -> after 13 increments sec=11, ns=4, with a single pps pulse on the rollover cycle.
REQ-024 Period 8, adj_ld adj_cnt=100 period_adj=+8 -> adj_busy high exactly 100 cycles, ns advances 16 per cycle, time ends 800 ns ahead, one adj_done pulse.
REQ-025 Period 8, period_adj=-16 (0xF0_00000000) adj_cnt=100 -> time frozen 100 cycles, then resumes at 8 per cycle.
REQ-026 Period 0x08_10200000 -> after 2^10 cycles, fractional carry matches the exact accumulated sum; captured values via cap_req equal live values of the request cycle.
REQ-027 time_ns_in integer 1000000 -> time_ld_err pulse, time unchanged; rst asserted mid-adjust -> all outputs 0, adj_done never pulses.
